// File: rtl/text_render_if.sv
// Signal bundle between the text-mode front end, font ROM, palette writer and the pixel pipe.
// The pipe takes the slave side; whoever drives cells, ROM rows and palette writes is master.
interface text_render_if #(
  parameter int unsigned GLYPH_W    = 8,
  parameter int unsigned GLYPH_H    = 16,
  parameter int unsigned CHAR_BITS  = 8,
  parameter int unsigned COLOR_BITS = 8,
  parameter int unsigned PAL_IDX    = 4
);
  localparam int unsigned COL_W = (GLYPH_W > 1) ? $clog2(GLYPH_W) : 1;
  localparam int unsigned ROW_W = (GLYPH_H > 1) ? $clog2(GLYPH_H) : 1;

  logic                        hsync;
  logic                        vsync;
  logic                        blank;
  logic [CHAR_BITS-1:0]        caracter;
  logic [2*PAL_IDX:0]          attr;
  logic [COL_W-1:0]            columna;
  logic [ROW_W-1:0]            fila;
  logic                        cursor_en;
  logic                        cursor_hit;
  logic [CHAR_BITS+ROW_W-1:0]  font_addr;
  logic [GLYPH_W-1:0]          caracter_fila;
  logic                        pal_we;
  logic [PAL_IDX-1:0]          pal_addr;
  logic [3*COLOR_BITS-1:0]     pal_wdata;
  logic [COLOR_BITS-1:0]       R_out;
  logic [COLOR_BITS-1:0]       G_out;
  logic [COLOR_BITS-1:0]       B_out;
  logic                        hsync_out;
  logic                        vsync_out;
  logic                        blink_phase;

  modport master (
    output hsync, vsync, blank, caracter, attr, columna, fila, cursor_en, cursor_hit,
    output caracter_fila, pal_we, pal_addr, pal_wdata,
    input  font_addr, R_out, G_out, B_out, hsync_out, vsync_out, blink_phase
  );

  modport slave (
    input  hsync, vsync, blank, caracter, attr, columna, fila, cursor_en, cursor_hit,
    input  caracter_fila, pal_we, pal_addr, pal_wdata,
    output font_addr, R_out, G_out, B_out, hsync_out, vsync_out, blink_phase
  );
endinterface

// File: rtl/text_render_pipe.sv
// Three-stage VGA text-mode pixel pipe: font lookup, pixel decision (blink/cursor/blank),
// palette lookup. Syncs ride alongside so they leave aligned with RGB.
module text_render_pipe #(
  parameter int unsigned GLYPH_W      = 8,
  parameter int unsigned GLYPH_H      = 16,
  parameter int unsigned CHAR_BITS    = 8,
  parameter int unsigned COLOR_BITS   = 8,
  parameter int unsigned PAL_IDX      = 4,
  parameter int unsigned BLINK_FRAMES = 30,
  parameter int unsigned CURSOR_ROW   = 14,
  parameter bit          SYNC_IDLE    = 1'b1
) (
  input logic          clk,
  input logic          rst,
  text_render_if.slave bus
);
  localparam int unsigned COL_W    = (GLYPH_W > 1) ? $clog2(GLYPH_W) : 1;
  localparam int unsigned ROW_W    = (GLYPH_H > 1) ? $clog2(GLYPH_H) : 1;
  localparam int unsigned PAL_SIZE = 1 << PAL_IDX;
  localparam int unsigned RGB_W    = 3 * COLOR_BITS;
  localparam int unsigned FRM_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  // S1
  logic [CHAR_BITS+ROW_W-1:0] font_addr_q;
  logic [2*PAL_IDX:0]         attr_s1;
  logic [COL_W-1:0]           col_s1;
  logic [ROW_W-1:0]           fila_s1;
  logic                       blank_s1, cur_s1, hs_s1, vs_s1;
  // S2
  logic                       blank_s2, hs_s2, vs_s2;
  logic [PAL_IDX-1:0]         idx_s2;
  // S3
  logic [RGB_W-1:0]           rgb_q;
  logic                       hs_q, vs_q;
  // Blink
  logic [FRM_W-1:0]           frame_q;
  logic                       phase_q, vs_prev_q;

  logic [RGB_W-1:0]           pal_q [PAL_SIZE];

  logic                       glyph_bit, pix_bit;
  logic [PAL_IDX-1:0]         idx_d;

  always_comb begin
    glyph_bit = bus.caracter_fila[COL_W'(GLYPH_W - 1) - col_s1];
    pix_bit   = glyph_bit;
    if (attr_s1[2*PAL_IDX] && phase_q) pix_bit = 1'b0;
    // Underline cursor blinks with the global phase, independent of the cell blink attribute.
    if (cur_s1 && !phase_q && (fila_s1 >= ROW_W'(CURSOR_ROW))) pix_bit = ~pix_bit;
    idx_d = pix_bit ? attr_s1[PAL_IDX-1:0] : attr_s1[2*PAL_IDX-1:PAL_IDX];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      font_addr_q <= '0;
      attr_s1     <= '0;
      col_s1      <= '0;
      fila_s1     <= '0;
      cur_s1      <= 1'b0;
      // Flushed stages read as blanked so nothing but black leaves the pipe after release.
      blank_s1    <= 1'b1;
      blank_s2    <= 1'b1;
      idx_s2      <= '0;
      hs_s1       <= SYNC_IDLE;
      vs_s1       <= SYNC_IDLE;
      hs_s2       <= SYNC_IDLE;
      vs_s2       <= SYNC_IDLE;
      hs_q        <= SYNC_IDLE;
      vs_q        <= SYNC_IDLE;
      rgb_q       <= '0;
    end else begin
      font_addr_q <= {bus.caracter, bus.fila};
      attr_s1     <= bus.attr;
      col_s1      <= bus.columna;
      fila_s1     <= bus.fila;
      blank_s1    <= bus.blank;
      cur_s1      <= bus.cursor_hit & bus.cursor_en;
      hs_s1       <= bus.hsync;
      vs_s1       <= bus.vsync;
      blank_s2    <= blank_s1;
      idx_s2      <= idx_d;
      hs_s2       <= hs_s1;
      vs_s2       <= vs_s1;
      rgb_q       <= blank_s2 ? '0 : pal_q[idx_s2];
      hs_q        <= hs_s2;
      vs_q        <= vs_s2;
    end
  end

  // Lookup and write share an edge, so a same-cycle read of the written entry sees the old value.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(PAL_SIZE); i++) begin
        pal_q[i] <= (i == 0) ? '0 : '1;
      end
    end else if (bus.pal_we) begin
      pal_q[bus.pal_addr] <= bus.pal_wdata;
    end
  end

  always_ff @(posedge clk) begin
    vs_prev_q <= bus.vsync;
    if (rst) begin
      frame_q <= '0;
      phase_q <= 1'b0;
    end else if (bus.vsync && !vs_prev_q) begin
      if (frame_q == FRM_W'(BLINK_FRAMES - 1)) begin
        frame_q <= '0;
        phase_q <= ~phase_q;
      end else begin
        frame_q <= frame_q + 1'b1;
      end
    end
  end

  assign bus.font_addr   = font_addr_q;
  assign bus.R_out       = rgb_q[3*COLOR_BITS-1:2*COLOR_BITS];
  assign bus.G_out       = rgb_q[2*COLOR_BITS-1:COLOR_BITS];
  assign bus.B_out       = rgb_q[COLOR_BITS-1:0];
  assign bus.hsync_out   = hs_q;
  assign bus.vsync_out   = vs_q;
  assign bus.blink_phase = phase_q;
endmodule

// File: tb/tb_text_render_pipe.sv
// Directed bench for text_render_pipe: glyph decode, blank, sync delay, palette, blink,
// cursor and mid-line reset, with a tiny behavioural font ROM.
module tb_text_render_pipe;
  localparam logic [23:0] BLACK = 24'h000000;
  localparam logic [23:0] WHITE = 24'hFFFFFF;
  localparam logic [23:0] GREEN = 24'h00FF00;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  text_render_if bus ();

  text_render_pipe #(
    .BLINK_FRAMES(2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Row content depends only on the character code.
  function automatic logic [7:0] rom_row(input logic [7:0] c);
    case (c)
      8'h01:   rom_row = 8'h81;
      8'h02:   rom_row = 8'hFF;
      default: rom_row = 8'h00;
    endcase
  endfunction

  assign bus.caracter_fila = rom_row(bus.font_addr[11:4]);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic pulse_vsync();
    bus.vsync = 1'b1;
    tick();
    bus.vsync = 1'b0;
    tick();
  endtask

  function automatic logic [31:0] rgb();
    rgb = {8'h00, bus.R_out, bus.G_out, bus.B_out};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst            = 1'b1;
    bus.hsync      = 1'b0;
    bus.vsync      = 1'b0;
    bus.blank      = 1'b0;
    bus.caracter   = '0;
    bus.attr       = '0;
    bus.columna    = '0;
    bus.fila       = '0;
    bus.cursor_en  = 1'b0;
    bus.cursor_hit = 1'b0;
    bus.pal_we     = 1'b0;
    bus.pal_addr   = '0;
    bus.pal_wdata  = '0;
    ticks(2);
    chk("reset_rgb", rgb(), BLACK);
    chk("reset_font_addr", 32'(bus.font_addr), 32'h0);
    chk("reset_blink_phase", 32'(bus.blink_phase), 32'h0);
    chk("reset_hsync_out", 32'(bus.hsync_out), 32'h1);
    chk("reset_vsync_out", 32'(bus.vsync_out), 32'h1);

    // Glyph row 8'h81, fg=1 (white), bg=0 (black), columns 0..7 streamed back-to-back.
    rst          = 1'b0;
    bus.caracter = 8'h01;
    bus.fila     = 4'd3;
    bus.attr     = 9'h001;
    for (int i = 0; i < 10; i++) begin
      if (i < 8) bus.columna = 3'(i);
      tick();
      if (i == 0) chk("font_addr", 32'(bus.font_addr), 32'h013);
      if (i == 1) chk("hsync_out_idle_flush", 32'(bus.hsync_out), 32'h1);
      if (i == 2) chk("hsync_out_follows", 32'(bus.hsync_out), 32'h0);
      if (i >= 2) begin
        chk($sformatf("glyph_col%0d", i - 2), rgb(), ((i - 2 == 0) || (i - 2 == 7)) ? WHITE : BLACK);
      end
    end

    // Blank overrides a solid glyph row.
    bus.caracter = 8'h02;
    bus.columna  = 3'd0;
    bus.blank    = 1'b1;
    ticks(3);
    chk("blank_ff", rgb(), BLACK);
    bus.blank = 1'b0;
    ticks(3);
    chk("unblank_ff", rgb(), WHITE);

    // hsync delay of exactly 3 cycles.
    bus.hsync = 1'b1;
    ticks(2);
    chk("hsync_rise_n2", 32'(bus.hsync_out), 32'h0);
    tick();
    chk("hsync_rise_n3", 32'(bus.hsync_out), 32'h1);
    bus.hsync = 1'b0;
    ticks(3);
    chk("hsync_fall_n3", 32'(bus.hsync_out), 32'h0);

    // Palette write lands on the same edge as a lookup of that entry.
    bus.attr = 9'h003;
    ticks(2);
    bus.pal_we    = 1'b1;
    bus.pal_addr  = 4'd3;
    bus.pal_wdata = GREEN;
    tick();
    chk("pal_same_cycle_old", rgb(), WHITE);
    bus.pal_we = 1'b0;
    tick();
    chk("pal_new_R", 32'(bus.R_out), 32'h00);
    chk("pal_new_G", 32'(bus.G_out), 32'hFF);
    chk("pal_new_B", 32'(bus.B_out), 32'h00);

    // Blink: fg=3 green, bg=2 white, two vsync rises per phase flip.
    bus.attr = 9'h123;
    ticks(3);
    chk("blink_ph0_fg", rgb(), GREEN);
    bus.vsync = 1'b1;
    tick();
    bus.vsync = 1'b0;
    ticks(2);
    chk("vsync_out_n3", 32'(bus.vsync_out), 32'h1);
    tick();
    chk("vsync_out_fall", 32'(bus.vsync_out), 32'h0);
    chk("blink_after_1rise", 32'(bus.blink_phase), 32'h0);
    bus.vsync = 1'b1;
    tick();
    chk("blink_after_2rise", 32'(bus.blink_phase), 32'h1);
    bus.vsync = 1'b0;
    ticks(3);
    chk("blink_ph1_bg", rgb(), WHITE);
    bus.attr = 9'h023;
    ticks(3);
    chk("noblink_attr_ph1_fg", rgb(), GREEN);
    bus.attr = 9'h123;
    pulse_vsync();
    pulse_vsync();
    chk("blink_after_4rise", 32'(bus.blink_phase), 32'h0);
    ticks(3);
    chk("blink_ph0_again_fg", rgb(), GREEN);

    // Cursor underline on an empty glyph row.
    bus.caracter   = 8'h00;
    bus.attr       = 9'h023;
    bus.cursor_en  = 1'b1;
    bus.cursor_hit = 1'b1;
    bus.fila       = 4'd14;
    ticks(3);
    chk("cursor_row14", rgb(), GREEN);
    bus.fila = 4'd15;
    ticks(3);
    chk("cursor_row15", rgb(), GREEN);
    bus.fila = 4'd13;
    ticks(3);
    chk("cursor_row13", rgb(), WHITE);
    bus.fila       = 4'd14;
    bus.cursor_hit = 1'b0;
    ticks(3);
    chk("cursor_no_hit", rgb(), WHITE);
    bus.cursor_hit = 1'b1;
    pulse_vsync();
    pulse_vsync();
    ticks(3);
    chk("cursor_hidden_ph1", rgb(), WHITE);

    // One-cycle reset in the middle of a line.
    bus.cursor_en  = 1'b0;
    bus.cursor_hit = 1'b0;
    bus.caracter   = 8'h02;
    bus.attr       = 9'h003;
    bus.fila       = 4'd0;
    ticks(3);
    chk("pre_rst_green", rgb(), GREEN);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_rgb", rgb(), BLACK);
    chk("rst_font_addr", 32'(bus.font_addr), 32'h0);
    chk("rst_blink_phase", 32'(bus.blink_phase), 32'h0);
    chk("rst_hsync_out", 32'(bus.hsync_out), 32'h1);
    tick();
    chk("rel_rgb_1", rgb(), BLACK);
    tick();
    chk("rel_rgb_2", rgb(), BLACK);
    tick();
    chk("rel_pal_default", rgb(), WHITE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
